// File: rtl/bp_pkg.sv
// bp_pkg: shared counter type, counter constants and FSM states for the branch history table
package bp_pkg;
  typedef logic [1:0] ctr_t;
  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;
  typedef enum logic {INIT, RUN} state_e;
endpackage

// File: rtl/bp_ctr_next.sv
// bp_ctr_next: saturating 2-bit counter step toward the resolved direction
module bp_ctr_next
  import bp_pkg::*;
(
  input  ctr_t ctr_i,
  input  logic taken_i,
  output ctr_t ctr_o
);
  // counters stick at the strong states instead of wrapping
  always_comb ctr_o = taken_i ? ((ctr_i == CTR_ST) ? ctr_i : ctr_i + 2'b01)
                              : ((ctr_i == CTR_SNT) ? ctr_i : ctr_i - 2'b01);
endmodule

// File: rtl/bht_predictor.sv
// bht_predictor: bimodal BHT with init sweep; define BHT_GSHARE_EN for gshare indexing
module bht_predictor
  import bp_pkg::*;
#(
  parameter int   INDEX_W  = 6,
  parameter int   PC_W     = 32,
  parameter ctr_t INIT_VAL = CTR_WNT
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               ready,
  input  logic               lookup_valid,
  input  logic [PC_W-1:0]    lookup_pc,
  output logic               pred_valid,
  output logic               pred_taken,
  output logic [1:0]         pred_counter,
  output logic [INDEX_W-1:0] pred_index,
  input  logic               upd_valid,
  input  logic [INDEX_W-1:0] upd_index,
  input  logic               upd_taken
);
  localparam int DEPTH = 1 << INDEX_W;
  state_e             state_q, state_d;
  logic [INDEX_W-1:0] ptr_q, ptr_d, lidx, pred_index_q;
  ctr_t               tbl_q [DEPTH];
  ctr_t               upd_nxt, rd_ctr, pred_counter_q;
  logic               lk_en, up_en, pred_valid_q;
  logic               unused_pc;
  assign ready = state_q == RUN;
  assign lk_en = lookup_valid & ready;
  assign up_en = upd_valid & ready;
  assign unused_pc = ^{lookup_pc[PC_W-1:INDEX_W+2], lookup_pc[1:0]};
`ifdef BHT_GSHARE_EN
  logic [INDEX_W-1:0] ghr_q;
  // global history shifts in each accepted resolved outcome
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ghr_q <= '0;
    else if (up_en) ghr_q <= {ghr_q[INDEX_W-2:0], upd_taken};
  assign lidx = lookup_pc[INDEX_W+1:2] ^ ghr_q;
`else
  assign lidx = lookup_pc[INDEX_W+1:2];
`endif
  bp_ctr_next u_next (.ctr_i(tbl_q[upd_index]), .taken_i(upd_taken), .ctr_o(upd_nxt));
  // same-entry update wins so the prediction sees the post-update counter
  always_comb rd_ctr = (up_en && upd_index == lidx) ? upd_nxt : tbl_q[lidx];
  // sweep pointer walks every entry once, then the table stays in RUN until reset
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == INIT) begin
      ptr_d   = ptr_q + 1'b1;
      state_d = (&ptr_q) ? RUN : INIT;
    end
  end
  // FSM and sweep pointer registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  // counter storage has no reset; the sweep initialises it
  always_ff @(posedge clk)
    if (state_q == INIT) tbl_q[ptr_q] <= INIT_VAL;
    else if (up_en) tbl_q[upd_index] <= upd_nxt;
  // prediction registers hold their last value between accepted lookups
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pred_valid_q   <= 1'b0;
      pred_counter_q <= CTR_SNT;
      pred_index_q   <= '0;
    end else begin
      pred_valid_q <= lk_en;
      if (lk_en) begin
        pred_counter_q <= rd_ctr;
        pred_index_q   <= lidx;
      end
    end
  assign pred_valid   = pred_valid_q;
  assign pred_counter = pred_counter_q;
  assign pred_taken   = pred_counter_q[1];
  assign pred_index   = pred_index_q;
endmodule

// File: tb/tb_bht_predictor.sv
// tb_bht_predictor: randomized check of bht_predictor against a table-of-integers model
module tb_bht_predictor;
  logic        clk = 0, rst_n = 0, ready;
  logic        lookup_valid = 0, upd_valid = 0, upd_taken = 0;
  logic [31:0] lookup_pc = 0;
  logic [5:0]  upd_index = 0;
  logic        pred_valid, pred_taken;
  logic [1:0]  pred_counter;
  logic [5:0]  pred_index;
  int checks = 0, failures = 0;
  int model [64];
  int ghr = 0, e_ctr = 0, e_idx = 0, e_pv = 0;
`ifdef BHT_GSHARE_EN
  localparam bit GS = 1;
  localparam int EXP6 = 6;
`else
  localparam bit GS = 0;
  localparam int EXP6 = 0;
`endif

  bht_predictor dut (
    .clk(clk), .rst_n(rst_n), .ready(ready),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .pred_counter(pred_counter), .pred_index(pred_index),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    foreach (model[i]) model[i] = 1;
    ghr = 0; e_ctr = 0; e_idx = 0; e_pv = 0;
  endtask

  // one clock with the given inputs; model advances, then all outputs are compared
  task automatic step(input bit lv, input logic [31:0] pc, input bit uv, input int ui, input bit ut);
    bit r;
    int idx;
    lookup_valid = lv; lookup_pc = pc; upd_valid = uv; upd_index = ui[5:0]; upd_taken = ut;
    r = ready;
    @(posedge clk);
    e_pv = lv & r;
    if (r) begin
      idx = int'(pc[7:2]) ^ ghr;
      if (uv) begin
        model[ui] = ut ? ((model[ui] + 1 > 3) ? 3 : model[ui] + 1)
                       : ((model[ui] - 1 < 0) ? 0 : model[ui] - 1);
        if (GS) ghr = ((ghr << 1) | int'(ut)) & 63;
      end
      if (lv) begin
        e_ctr = model[idx];
        e_idx = idx;
      end
    end
    #1;
    check("pred_valid", pred_valid, e_pv);
    check("pred_counter", pred_counter, e_ctr);
    check("pred_taken", pred_taken, e_ctr / 2);
    check("pred_index", pred_index, e_idx);
  endtask

  // release reset, poke inputs during the sweep and measure its length
  task automatic init_seq();
    int n = 0;
    bit bad = 0;
    rst_n = 1;
    while (!ready && n < 200) begin
      lookup_valid = 1'($urandom); lookup_pc = $urandom;
      upd_valid = 1'($urandom); upd_index = 6'($urandom); upd_taken = 1'($urandom);
      @(posedge clk);
      n++;
      #1;
      if (pred_valid !== 1'b0) bad = 1;
    end
    lookup_valid = 0; upd_valid = 0;
    check("ready_latency", n, 64);
    check("init_pred_valid", bad, 0);
    check("init_pred_counter", pred_counter, 0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", ready, 0);
    check("rst_pred_valid", pred_valid, 0);
    init_seq();
    for (int i = 0; i < 64; i++) step(1, i << 2, 0, 0, 0);
    step(1, 32'h100, 0, 0, 0);
    check("t1_index", pred_index, 0);
    check("t1_counter", pred_counter, 1);
    check("t1_taken", pred_taken, 0);
    repeat (3) step(0, 0, 1, 0, 1);
    step(1, 32'h100, 0, 0, 0);
    repeat (4) step(0, 0, 1, 0, 0);
    step(1, 32'h100, 0, 0, 0);
    step(1, 32'h14, 1, 5, 1);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] pc;
      pc = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      step(1'($urandom), pc, 1'($urandom), $urandom_range(0, 7), 1'($urandom));
    end
    for (int i = 0; i < 64; i++) step(1, i << 2, 0, 0, 0);
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    check("arst_ready", ready, 0);
    check("arst_pred_valid", pred_valid, 0);
    check("arst_pred_counter", pred_counter, 0);
    check("arst_pred_index", pred_index, 0);
    check("arst_pred_taken", pred_taken, 0);
    model_reset();
    @(posedge clk);
    #1;
    init_seq();
    step(1, 32'h100, 0, 0, 0);
    check("rerun_counter", pred_counter, 1);
    step(0, 0, 1, 9, 1);
    step(0, 0, 1, 9, 1);
    step(0, 0, 1, 9, 0);
    step(1, 32'h100, 0, 0, 0);
    check("ghr_index", pred_index, EXP6);
    for (int i = 0; i < 64; i++) step(1, i << 2, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bht_predictor.md
Name: bht_predictor

Overview:
Bimodal branch history table: an array of 2-bit saturating counters that predicts taken/not-taken for fetched branches and trains on resolved outcomes.
- The lookup port sits in the fetch stage; the update port is driven from branch resolution in execute.
- It houses the counter array and the saturating next-value update logic.
- After reset, an init sweep walks the table and writes the initial counter value into every entry.

Parameters:
- INDEX_W, 6, table index width; depth = 2^INDEX_W entries (64).
- PC_W, 32, program counter width.
- INIT_VAL, 2'b01, counter value written by the init sweep (weakly not-taken).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ready  output  1  high once the init sweep is done; lookups and updates are accepted only while high.
- lookup_valid  input  1  lookup request this cycle.
- lookup_pc  input  PC_W  branch PC to predict.
- pred_valid  output  1  registered; prediction outputs are valid.
- pred_taken  output  1  registered; predicted direction, equal to counter MSB.
- pred_counter  output  2  registered; full counter value read.
- pred_index  output  INDEX_W  registered; table index used. The pipeline carries it back to upd_index.
- upd_valid  input  1  training request this cycle.
- upd_index  input  INDEX_W  entry to train (the pred_index captured at fetch).
- upd_taken  input  1  resolved direction; 1 = taken.

Behaviour:
- Index: idx = lookup_pc[INDEX_W+1:2]; PC bits [1:0] are ignored.
- Async reset (rst_n low), effective immediately regardless of clk:
  - ready=0, pred_valid=0, pred_taken=0, pred_counter=2'b00, pred_index=0.
  - FSM goes to INIT; sweep pointer = 0.
  - Table storage is not reset directly; the sweep initialises it.
- FSM states: INIT, RUN.
  - INIT: each cycle writes INIT_VAL to entry[ptr], then ptr++. When ptr = 2^INDEX_W-1 is written, the FSM moves to RUN.
  - ready rises exactly 2^INDEX_W cycles after rst_n deasserts.
  - During INIT, lookup_valid and upd_valid are ignored; pred_valid stays 0.
  - RUN: there is no exit except reset.
- Lookup latency is 1 cycle. At each edge:
  - pred_valid <= lookup_valid & ready.
  - pred_counter, pred_index and pred_taken update only when lookup_valid & ready; otherwise they hold their value.
- Update is a single-cycle read-modify-write, applied when upd_valid & ready:
  - taken: counter = min(counter+1, 2'b11).
  - not-taken: counter = max(counter-1, 2'b00).
  - There is no wrap-around in either direction.
- Simultaneous lookup and update on the same index: write-first bypass, so the prediction returns the post-update counter.
- Lookup and update on different indices in the same cycle proceed independently.
- Reset mid-sweep or mid-operation: the sweep restarts from entry 0 and all trained state is discarded.

Optional Feature:
- Macro: BHT_GSHARE_EN.
- With the macro defined, the block adds an INDEX_W-bit global history register (ghr):
  - ghr resets to 0.
  - On every accepted update, ghr <= {ghr[INDEX_W-2:0], upd_taken}.
  - Lookup index = lookup_pc[INDEX_W+1:2] XOR ghr, using the ghr value before any same-cycle update.
  - pred_index reports the XORed index.
  - ghr does not change during INIT.
- Without the macro: pure bimodal indexing; no ghr storage exists.

Decomposition:
- Package bp_pkg holds:
  - 2-bit counter typedef.
  - Constants CTR_SNT=00, CTR_WNT=01, CTR_WT=10, CTR_ST=11.
  - FSM state enum {INIT, RUN}.
- Sub-module bp_ctr_next: purely combinational (counter, taken) -> saturating next counter, instantiated once on the update path.

Test Plan (INDEX_W=6):
1. Release rst_n -> ready=0 for 64 cycles, 1 on cycle 64. Then lookup pc=0x0000_0100 -> next cycle pred_valid=1, pred_index=0, pred_counter=01, pred_taken=0.
2. Three taken updates at index 0 -> counter 01->10->11->11. Lookup pc 0x100 -> pred_counter=11, pred_taken=1.
3. Four not-taken updates at index 0 from 11 -> 10, 01, 00, 00 (saturates). Lookup returns 00.
4. Entry 5 at 01; same cycle: lookup pc=0x14 plus upd_index=5, upd_taken=1 -> next cycle pred_counter=10 (bypass).
5. Lookup and update pulses during INIT -> pred_valid stays 0; all entries still read 01 after ready. Pull rst_n low after training -> outputs clear immediately, 64-cycle sweep reruns, index 0 reads 01.
6. With BHT_GSHARE_EN: updates taken, taken, not-taken -> ghr=6'b000110. Lookup pc 0x100 -> pred_index=6.
